// File: rtl/ctrl_bubble_reg.sv
// ID/EX control-bundle pipeline register with stall, flush and multi-cycle bubble insertion.
// Define CTRL_BUBBLE_STATS_EN to build the saturating bubble_cnt statistics counter.
module ctrl_bubble_reg #(
   parameter int CTRL_W     = 13,
   parameter int BUBBLE_MAX = 3,
   parameter int LEN_W      = $clog2(BUBBLE_MAX + 1),
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic              valid_in,
   input  logic              stall,
   input  logic              flush,
   input  logic              bubble_req,
   input  logic [LEN_W-1:0]  bubble_len,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic              valid_out,
   output logic              hold_up,
   output logic [CNT_W-1:0]  bubble_cnt
);

   // state  | meaning
   // IDLE   | normal load, or start of a bubble sequence
   // INSERT | bubbles pending in rem, ID/IF held via hold_up
   typedef enum logic {IDLE, INSERT} state_t;

   localparam logic [LEN_W-1:0] BMAX_L = LEN_W'(BUBBLE_MAX);
   localparam logic [LEN_W-1:0] ONE_L  = LEN_W'(1);

   state_t           state;
   logic [LEN_W-1:0] rem;
   logic [LEN_W-1:0] eff_len;
   logic             req_ok;

   assign eff_len = (bubble_len > BMAX_L) ? BMAX_L : bubble_len;
   assign req_ok  = bubble_req && (bubble_len != '0);
   assign hold_up = (state == INSERT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rem       <= '0;
         ctrl_out  <= '0;
         valid_out <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         rem       <= '0;
         ctrl_out  <= '0;
         valid_out <= 1'b0;
      end else if (!stall) begin
         case (state)
            INSERT: begin
               ctrl_out  <= '0;
               valid_out <= 1'b0;
               rem       <= rem - ONE_L;
               if (rem == ONE_L)
                  state <= IDLE;
            end
            default: begin
               if (req_ok) begin
                  ctrl_out  <= '0;
                  valid_out <= 1'b0;
                  rem       <= eff_len - ONE_L;
                  if (eff_len > ONE_L)
                     state <= INSERT;
               end else begin
                  valid_out <= valid_in;
                  ctrl_out  <= valid_in ? ctrl_in : '0;
               end
            end
         endcase
      end
   end

`ifdef CTRL_BUBBLE_STATS_EN
   // Flush overrides stall, so a flush edge always counts as an inserted bubble.
   logic bubble_load;
   assign bubble_load = flush || (!stall && ((state == INSERT) || req_ok));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bubble_cnt <= '0;
      else if (bubble_load && (bubble_cnt != {CNT_W{1'b1}}))
         bubble_cnt <= bubble_cnt + CNT_W'(1);
   end
`else
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_bubble_reg.sv
// Self-checking bench: two ctrl_bubble_reg instances (default, and BUBBLE_MAX=2/CNT_W=3)
// driven by directed steps then random stimulus, compared to a pending-bubble model.
module tb_ctrl_bubble_reg;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [12:0] ctrl_in;
   logic        valid_in, stall, flush, bubble_req;
   logic [1:0]  bubble_len;

   logic [12:0] a_ctrl, b_ctrl;
   logic        a_valid, b_valid, a_hold, b_hold;
   logic [15:0] a_cnt;
   logic [2:0]  b_cnt;

   ctrl_bubble_reg dut_a (
      .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .valid_in(valid_in), .stall(stall),
      .flush(flush), .bubble_req(bubble_req), .bubble_len(bubble_len),
      .ctrl_out(a_ctrl), .valid_out(a_valid), .hold_up(a_hold), .bubble_cnt(a_cnt));

   ctrl_bubble_reg #(.CTRL_W(13), .BUBBLE_MAX(2), .CNT_W(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .valid_in(valid_in), .stall(stall),
      .flush(flush), .bubble_req(bubble_req), .bubble_len(bubble_len),
      .ctrl_out(b_ctrl), .valid_out(b_valid), .hold_up(b_hold), .bubble_cnt(b_cnt));

   int errors = 0;
   int checks = 0;

   // Model: per instance, the visible outputs plus a count of bubbles still owed.
   logic [12:0] m_ctrl [2];
   logic        m_valid[2];
   int          m_pend [2];
   int          m_cnt  [2];
   int          bmax   [2] = '{3, 2};
   int          cmax   [2] = '{65535, 7};

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ctrl[i] = '0; m_valid[i] = 1'b0; m_pend[i] = 0; m_cnt[i] = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         bit bub;
         bub = 1'b0;
         if (flush) begin
            m_pend[i] = 0; bub = 1'b1;
         end else if (!stall) begin
            if (m_pend[i] > 0) begin
               m_pend[i]--; bub = 1'b1;
            end else if (bubble_req && bubble_len != 0) begin
               m_pend[i] = ((int'(bubble_len) < bmax[i]) ? int'(bubble_len) : bmax[i]) - 1;
               bub = 1'b1;
            end else begin
               m_valid[i] = valid_in;
               m_ctrl[i]  = valid_in ? ctrl_in : 13'h0;
            end
         end
         if (bub) begin
            m_valid[i] = 1'b0; m_ctrl[i] = '0;
            if (m_cnt[i] < cmax[i]) m_cnt[i]++;
         end
      end
   endtask

   task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_all(string tag);
      logic [15:0] ea, eb;
`ifdef CTRL_BUBBLE_STATS_EN
      ea = 16'(m_cnt[0]); eb = 16'(m_cnt[1]);
`else
      ea = '0; eb = '0;
`endif
      chk({tag, ".a_ctrl"},  16'(a_ctrl),  16'(m_ctrl[0]));
      chk({tag, ".a_valid"}, 16'(a_valid), 16'(m_valid[0]));
      chk({tag, ".a_hold"},  16'(a_hold),  16'(m_pend[0] > 0));
      chk({tag, ".a_cnt"},   a_cnt,        ea);
      chk({tag, ".b_ctrl"},  16'(b_ctrl),  16'(m_ctrl[1]));
      chk({tag, ".b_valid"}, 16'(b_valid), 16'(m_valid[1]));
      chk({tag, ".b_hold"},  16'(b_hold),  16'(m_pend[1] > 0));
      chk({tag, ".b_cnt"},   16'(b_cnt),   eb);
   endtask

   task automatic step(string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      rst_n = 1'b0; ctrl_in = 13'h1FFF; valid_in = 1'b1;
      stall = 1'b0; flush = 1'b0; bubble_req = 1'b0; bubble_len = 2'd0;
      #2;
      model_reset();
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step("first_load");

      // Length-3 request: 3 bubbles on dut_a, clamped to 2 on dut_b.
      bubble_req = 1'b1; bubble_len = 2'd3; ctrl_in = 13'h0AAA;
      step("bub3_1");
      bubble_req = 1'b0;
      step("bub3_2");
      step("bub3_3");
      step("bub3_load");

      // Stall after the first bubble must not consume a bubble.
      bubble_req = 1'b1; ctrl_in = 13'h1555;
      step("stl_1");
      bubble_req = 1'b0; stall = 1'b1;
      step("stl_hold");
      stall = 1'b0;
      step("stl_2");
      step("stl_3");
      step("stl_load");

      // Flush wins over stall.
      flush = 1'b1; stall = 1'b1;
      step("flush_stall");
      flush = 1'b0; stall = 1'b0;
      step("after_flush");

      // Flush mid-sequence drops hold_up, then a normal load follows.
      bubble_req = 1'b1; bubble_len = 2'd3; ctrl_in = 13'h0123;
      step("fl_seq_1");
      bubble_req = 1'b0; flush = 1'b1;
      step("fl_seq_flush");
      flush = 1'b0;
      step("fl_seq_load");

      // Zero length request behaves as a normal load; invalid load zeroes ctrl.
      bubble_req = 1'b1; bubble_len = 2'd0; ctrl_in = 13'h0F0F;
      step("len0");
      bubble_req = 1'b0; valid_in = 1'b0;
      step("invalid_load");
      valid_in = 1'b1;

      // Asynchronous reset mid-sequence abandons it at once.
      bubble_req = 1'b1; bubble_len = 2'd3;
      step("rst_seq_1");
      bubble_req = 1'b0;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("rst_mid");
      #1;
      rst_n = 1'b1;
      step("rst_after");

      for (int n = 0; n < 800; n++) begin
         ctrl_in    = 13'($urandom);
         valid_in   = ($urandom_range(0, 3) != 0);
         stall      = ($urandom_range(0, 7) == 0);
         flush      = ($urandom_range(0, 15) == 0);
         bubble_req = ($urandom_range(0, 3) == 0);
         bubble_len = 2'($urandom_range(0, 3));
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
